// File: rtl/mem_net_bram_server.sv
// rtl/mem_net_bram_server.sv - BRAM-backed memory-network responder with 2-entry in-order response buffer
module mem_net_bram_server #(
    parameter int p_opaq_bits = 8,
    parameter int p_addr_bits = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_val,
    output logic                   req_rdy,
    input  logic                   req_msg_op,
    input  logic [p_opaq_bits-1:0] req_msg_opaque,
    input  logic [31:0]            req_msg_addr,
    input  logic [3:0]             req_msg_strb,
    input  logic [31:0]            req_msg_data,
    input  logic [1:0]             req_msg_origin,
    output logic                   resp_val,
    input  logic                   resp_rdy,
    output logic                   resp_msg_op,
    output logic [p_opaq_bits-1:0] resp_msg_opaque,
    output logic [31:0]            resp_msg_addr,
    output logic [3:0]             resp_msg_strb,
    output logic [31:0]            resp_msg_data,
    output logic [1:0]             resp_msg_origin
);

    localparam int lp_depth = 1 << p_addr_bits;

    // Word array and its synchronous read port; no reset so contents survive rst
    logic [31:0] r_mem [lp_depth];
    logic [31:0] r_rdata;

    // Response buffer: occupancy, 1-bit circular pointers and per-entry fields
    logic [1:0]             r_occ;
    logic                   r_head;
    logic                   r_tail;
    logic [1:0]             r_vld;
    logic [1:0]             r_fresh;
    logic                   r_op   [2];
    logic [p_opaq_bits-1:0] r_opq  [2];
    logic [31:0]            r_addr [2];
    logic [3:0]             r_strb [2];
    logic [31:0]            r_data [2];
    logic [1:0]             r_org  [2];

    logic                   w_req_fire;
    logic                   w_resp_fire;
    logic [p_addr_bits-1:0] w_idx;
    logic                   w_unused_addr;

    assign w_req_fire    = req_val && req_rdy;
    assign w_resp_fire   = resp_val && resp_rdy;
    assign w_idx         = req_msg_addr[p_addr_bits+1:2];
    // Region decode happens upstream, so the upper address bits and byte offset are dropped here
    assign w_unused_addr = &{1'b0, req_msg_addr[31:p_addr_bits+2], req_msg_addr[1:0]};

    // Ready depends only on registered occupancy, never on resp_rdy or req_val
    assign req_rdy = (r_occ < 2'd2);

    // Head entry drives the response; a read in its first cycle takes data straight from the RAM port
    assign resp_val        = r_vld[r_head];
    assign resp_msg_op     = r_op[r_head];
    assign resp_msg_opaque = r_opq[r_head];
    assign resp_msg_addr   = r_addr[r_head];
    assign resp_msg_strb   = r_strb[r_head];
    assign resp_msg_origin = r_org[r_head];
    assign resp_msg_data   = r_fresh[r_head] ? r_rdata : r_data[r_head];

    // Array access: byte-masked write or registered read, only on an accepted request
    always_ff @(posedge clk) begin
        if (w_req_fire) begin
            if (req_msg_op) begin
                for (int b = 0; b < 4; b++) begin
                    if (req_msg_strb[b]) begin
                        r_mem[w_idx][8*b +: 8] <= req_msg_data[8*b +: 8];
                    end
                end
            end else begin
                r_rdata <= r_mem[w_idx];
            end
        end
    end

    // Occupancy and pointer bookkeeping; simultaneous push and pop leave occupancy unchanged
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_occ  <= 2'd0;
            r_head <= 1'b0;
            r_tail <= 1'b0;
        end else begin
            case ({w_req_fire, w_resp_fire})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
            if (w_req_fire) begin
                r_tail <= ~r_tail;
            end
            if (w_resp_fire) begin
                r_head <= ~r_head;
            end
        end
    end

    // Entry storage: capture RAM data one cycle after a read accept, write metadata at accept
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vld   <= 2'b00;
            r_fresh <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                r_op[i]   <= 1'b0;
                r_opq[i]  <= '0;
                r_addr[i] <= '0;
                r_strb[i] <= '0;
                r_data[i] <= '0;
                r_org[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (r_fresh[i]) begin
                    r_data[i]  <= r_rdata;
                    r_fresh[i] <= 1'b0;
                end
            end
            if (w_resp_fire) begin
                r_vld[r_head] <= 1'b0;
            end
            if (w_req_fire) begin
                r_vld[r_tail]   <= 1'b1;
                r_fresh[r_tail] <= ~req_msg_op;
                r_op[r_tail]    <= req_msg_op;
                r_opq[r_tail]   <= req_msg_opaque;
                r_addr[r_tail]  <= req_msg_addr;
                r_strb[r_tail]  <= req_msg_strb;
                r_data[r_tail]  <= 32'd0;
                r_org[r_tail]   <= req_msg_origin;
            end
        end
    end

endmodule

// File: tb/tb_mem_net_bram_server.sv
// tb/tb_mem_net_bram_server.sv - directed and scoreboarded checks for mem_net_bram_server
module tb_mem_net_bram_server;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_val = 1'b0;
    logic        req_rdy;
    logic        req_msg_op = 1'b0;
    logic [7:0]  req_msg_opaque = '0;
    logic [31:0] req_msg_addr = '0;
    logic [3:0]  req_msg_strb = '0;
    logic [31:0] req_msg_data = '0;
    logic [1:0]  req_msg_origin = '0;
    logic        resp_val;
    logic        resp_rdy = 1'b1;
    logic        resp_msg_op;
    logic [7:0]  resp_msg_opaque;
    logic [31:0] resp_msg_addr;
    logic [3:0]  resp_msg_strb;
    logic [31:0] resp_msg_data;
    logic [1:0]  resp_msg_origin;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic        op;
        logic [7:0]  opq;
        logic [31:0] data;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    logic [31:0] mdl [8];
    int          cur_k;
    logic        fired;
    logic [7:0]  tag8;

    mem_net_bram_server #(.p_opaq_bits(8), .p_addr_bits(12)) dut (
        .clk(clk), .rst(rst),
        .req_val(req_val), .req_rdy(req_rdy),
        .req_msg_op(req_msg_op), .req_msg_opaque(req_msg_opaque),
        .req_msg_addr(req_msg_addr), .req_msg_strb(req_msg_strb),
        .req_msg_data(req_msg_data), .req_msg_origin(req_msg_origin),
        .resp_val(resp_val), .resp_rdy(resp_rdy),
        .resp_msg_op(resp_msg_op), .resp_msg_opaque(resp_msg_opaque),
        .resp_msg_addr(resp_msg_addr), .resp_msg_strb(resp_msg_strb),
        .resp_msg_data(resp_msg_data), .resp_msg_origin(resp_msg_origin)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic op, input logic [7:0] opq, input logic [31:0] addr,
                         input logic [3:0] strb, input logic [31:0] data, input logic [1:0] org);
        req_val        = 1'b1;
        req_msg_op     = op;
        req_msg_opaque = opq;
        req_msg_addr   = addr;
        req_msg_strb   = strb;
        req_msg_data   = data;
        req_msg_origin = org;
    endtask

    // One isolated transaction with resp_rdy high; entered and left 1 time unit after a rising edge
    task automatic txn(input logic op, input logic [7:0] opq, input logic [31:0] addr,
                       input logic [3:0] strb, input logic [31:0] data, input logic [1:0] org,
                       input logic [31:0] exp_data, input string tag);
        drive(op, opq, addr, strb, data, org);
        @(negedge clk);
        chk({tag, "_rdy"}, 32'(req_rdy), 32'd1);
        chk({tag, "_noval_n"}, 32'(resp_val), 32'd0);
        @(posedge clk); #1;
        req_val = 1'b0;
        @(negedge clk);
        chk({tag, "_val"}, 32'(resp_val), 32'd1);
        chk({tag, "_op"}, 32'(resp_msg_op), 32'(op));
        chk({tag, "_opq"}, 32'(resp_msg_opaque), 32'(opq));
        chk({tag, "_org"}, 32'(resp_msg_origin), 32'(org));
        chk({tag, "_data"}, resp_msg_data, exp_data);
        @(posedge clk); #1;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_val_in", 32'(resp_val), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_val", 32'(resp_val), 32'd0);
        chk("rst_rdy", 32'(req_rdy), 32'd1);
        chk("rst_data", resp_msg_data, 32'd0);
        chk("rst_opq", 32'(resp_msg_opaque), 32'd0);
        chk("rst_addr", resp_msg_addr, 32'd0);
        @(posedge clk); #1;

        // Preload array contents through the write path
        txn(1'b1, 8'h01, 32'h0, 4'hF, 32'hDEADBEEF, 2'd0, 32'd0, "pre0");
        txn(1'b1, 8'h02, 32'h10, 4'hF, 32'hFFFFFFFF, 2'd2, 32'd0, "pre10");
        txn(1'b1, 8'h03, 32'h20, 4'hF, 32'hCAFEF00D, 2'd1, 32'd0, "pre20");
        for (int i = 0; i < 16; i++) begin
            txn(1'b1, 8'(i), 32'h100 + 32'(4 * i), 4'hF, 32'h1000_0000 + 32'(i), 2'd0, 32'd0, "pre_str");
        end
        for (int k = 0; k < 8; k++) begin
            mdl[k] = 32'h3000_0000 + 32'(k * 32'h111);
            txn(1'b1, 8'(k), 32'h200 + 32'(4 * k), 4'hF, mdl[k], 2'd1, 32'd0, "pre_rnd");
        end

        // Test 1: plain read with tag and origin echo
        txn(1'b0, 8'h5A, 32'h0, 4'h0, 32'h0, 2'd1, 32'hDEADBEEF, "t1");

        // Test 2: partial write then read in the next cycle
        drive(1'b1, 8'h20, 32'h10, 4'b0101, 32'h11223344, 2'd1);
        @(negedge clk);
        chk("t2_rdy", 32'(req_rdy), 32'd1);
        @(posedge clk); #1;
        drive(1'b0, 8'h21, 32'h10, 4'h0, 32'h0, 2'd1);
        @(negedge clk);
        chk("t2_wval", 32'(resp_val), 32'd1);
        chk("t2_wop", 32'(resp_msg_op), 32'd1);
        chk("t2_wopq", 32'(resp_msg_opaque), 32'h20);
        chk("t2_wstrb", 32'(resp_msg_strb), 32'h5);
        chk("t2_wdata", resp_msg_data, 32'd0);
        chk("t2_rdy2", 32'(req_rdy), 32'd1);
        @(posedge clk); #1;
        req_val = 1'b0;
        @(negedge clk);
        chk("t2_rval", 32'(resp_val), 32'd1);
        chk("t2_ropq", 32'(resp_msg_opaque), 32'h21);
        chk("t2_rdata", resp_msg_data, 32'hFF22FF44);
        @(posedge clk); #1;
        txn(1'b1, 8'h33, 32'h10, 4'h0, 32'h0, 2'd2, 32'd0, "t2_noop");
        txn(1'b0, 8'h34, 32'h10, 4'h0, 32'h0, 2'd2, 32'hFF22FF44, "t2_after_noop");

        // Test 3: three reads against a stalled response port
        resp_rdy = 1'b0;
        drive(1'b0, 8'h01, 32'h0, 4'h0, 32'h0, 2'd0);
        @(negedge clk);
        chk("t3_rdy1", 32'(req_rdy), 32'd1);
        @(posedge clk); #1;
        drive(1'b0, 8'h02, 32'h10, 4'h0, 32'h0, 2'd1);
        @(negedge clk);
        chk("t3_rdy2", 32'(req_rdy), 32'd1);
        chk("t3_val_a", 32'(resp_val), 32'd1);
        chk("t3_data_a", resp_msg_data, 32'hDEADBEEF);
        @(posedge clk); #1;
        drive(1'b0, 8'h03, 32'h20, 4'h0, 32'h0, 2'd2);
        @(negedge clk);
        chk("t3_full", 32'(req_rdy), 32'd0);
        chk("t3_opq_b", 32'(resp_msg_opaque), 32'h01);
        chk("t3_data_b", resp_msg_data, 32'hDEADBEEF);
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("t3_hold_rdy", 32'(req_rdy), 32'd0);
        chk("t3_hold_data", resp_msg_data, 32'hDEADBEEF);
        @(posedge clk); #1;
        resp_rdy = 1'b1;
        @(negedge clk);
        chk("t3_r1_opq", 32'(resp_msg_opaque), 32'h01);
        chk("t3_r1_data", resp_msg_data, 32'hDEADBEEF);
        chk("t3_r1_rdy", 32'(req_rdy), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t3_r2_opq", 32'(resp_msg_opaque), 32'h02);
        chk("t3_r2_data", resp_msg_data, 32'hFF22FF44);
        chk("t3_r2_rdy", 32'(req_rdy), 32'd1);
        @(posedge clk); #1;
        req_val = 1'b0;
        @(negedge clk);
        chk("t3_r3_val", 32'(resp_val), 32'd1);
        chk("t3_r3_opq", 32'(resp_msg_opaque), 32'h03);
        chk("t3_r3_data", resp_msg_data, 32'hCAFEF00D);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t3_empty", 32'(resp_val), 32'd0);
        @(posedge clk); #1;

        // Test 4: 16 streaming reads, one response per cycle
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 8'(i), 32'h100 + 32'(4 * i), 4'h0, 32'h0, 2'd0);
            @(negedge clk);
            chk("t4_rdy", 32'(req_rdy), 32'd1);
            if (i > 0) begin
                chk("t4_val", 32'(resp_val), 32'd1);
                chk("t4_opq", 32'(resp_msg_opaque), 32'(i - 1));
                chk("t4_data", resp_msg_data, 32'h1000_0000 + 32'(i - 1));
            end else begin
                chk("t4_first_noval", 32'(resp_val), 32'd0);
            end
            @(posedge clk); #1;
        end
        req_val = 1'b0;
        @(negedge clk);
        chk("t4_last_opq", 32'(resp_msg_opaque), 32'd15);
        chk("t4_last_data", resp_msg_data, 32'h1000_000F);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t4_empty", 32'(resp_val), 32'd0);
        @(posedge clk); #1;

        // Test 5: random backpressure with mixed traffic against a scoreboard
        tag8  = 8'h80;
        fired = 1'b0;
        cur_k = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            resp_rdy = ($urandom_range(0, 99) < 60);
            if (!req_val && ($urandom_range(0, 99) < 70)) begin
                cur_k = int'($urandom_range(0, 7));
                drive(1'($urandom_range(0, 1)), tag8, 32'h200 + 32'(4 * cur_k),
                      4'($urandom_range(0, 15)), $urandom, 2'($urandom_range(0, 2)));
                tag8 = tag8 + 8'd1;
            end
            @(negedge clk);
            fired = 1'b0;
            if (resp_val && resp_rdy) begin
                if (q.size() == 0) begin
                    chk("t5_unexpected", 32'(resp_val), 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("t5_op", 32'(resp_msg_op), 32'(e.op));
                    chk("t5_opq", 32'(resp_msg_opaque), 32'(e.opq));
                    chk("t5_data", resp_msg_data, e.data);
                end
            end
            if (req_val && req_rdy) begin
                fired = 1'b1;
                e.op  = req_msg_op;
                e.opq = req_msg_opaque;
                if (req_msg_op) begin
                    e.data = 32'd0;
                    for (int b = 0; b < 4; b++) begin
                        if (req_msg_strb[b]) mdl[cur_k][8*b +: 8] = req_msg_data[8*b +: 8];
                    end
                end else begin
                    e.data = mdl[cur_k];
                end
                q.push_back(e);
            end
            @(posedge clk); #1;
            if (fired) req_val = 1'b0;
        end
        req_val  = 1'b0;
        resp_rdy = 1'b1;
        for (int d = 0; d < 10; d++) begin
            @(negedge clk);
            if (resp_val) begin
                if (q.size() == 0) begin
                    chk("t5_drain_unexpected", 32'(resp_val), 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("t5_drain_opq", 32'(resp_msg_opaque), 32'(e.opq));
                    chk("t5_drain_data", resp_msg_data, e.data);
                end
            end
            @(posedge clk); #1;
        end
        chk("t5_all_returned", 32'(q.size()), 32'd0);

        // Test 6: asynchronous reset with two responses pending
        resp_rdy = 1'b0;
        drive(1'b0, 8'h61, 32'h0, 4'h0, 32'h0, 2'd0);
        @(posedge clk); #1;
        drive(1'b0, 8'h62, 32'h10, 4'h0, 32'h0, 2'd1);
        @(posedge clk); #1;
        req_val = 1'b0;
        @(negedge clk);
        chk("t6_full", 32'(req_rdy), 32'd0);
        chk("t6_val", 32'(resp_val), 32'd1);
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        chk("t6_async_val", 32'(resp_val), 32'd0);
        chk("t6_async_rdy", 32'(req_rdy), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        resp_rdy = 1'b1;
        @(negedge clk);
        chk("t6_rel_val", 32'(resp_val), 32'd0);
        chk("t6_rel_rdy", 32'(req_rdy), 32'd1);
        chk("t6_rel_data", resp_msg_data, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("t6_no_spurious", 32'(resp_val), 32'd0);
        @(posedge clk); #1;
        txn(1'b0, 8'h63, 32'h10, 4'h0, 32'h0, 2'd1, 32'hFF22FF44, "t6_mem10");
        txn(1'b0, 8'h64, 32'h0, 4'h0, 32'h0, 2'd2, 32'hDEADBEEF, "t6_mem0");
        txn(1'b0, 8'h65, 32'h20C, 4'h0, 32'h0, 2'd0, mdl[3], "t6_mem20c");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
